cmos_rgb565_packer: RTL

// - Sits directly downstream of the 8->16 bit CMOS assembly stage.
// - Takes its RGB565 pixel stream (de + 16-bit data) plus the sensor vsync.
// - Counts pixels and lines against the configured frame size.
// - Packs PIX_PER_WORD consecutive pixels into one wide word for the frame-buffer write FIFO.
// - Flags malformed lines and frames; counts good frames.

---
 rtl/cmos_rgb565_packer_if.sv | 39 +++
 rtl/cmos_rgb565_packer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/cmos_rgb565_packer_if.sv
// rtl/cmos_rgb565_packer_if.sv - pixel-in / packed-word-out bundle for cmos_rgb565_packer
//
// Purpose: groups the RGB565 pixel stream, the sensor vsync and the
//          frame-buffer write side into one interface.
// Signals:
//   vs_i           sensor vsync, rising edge starts a frame
//   de_i           pixel valid
//   pdata_i[15:0]  RGB565 pixel
//   wr_en_o        one-cycle strobe, wr_data_o valid
//   wr_data_o      PIX_PER_WORD packed pixels, first pixel in [15:0]
//   frame_start_o  pulse on accepted vsync rise
//   frame_done_o   pulse after the last active line ends
//   line_err_o     sticky malformed-line flag for the current frame
//   frame_cnt_o    completed good frames, wraps
// Modports: master drives the pixel side and observes results,
//           slave is the packer itself.
interface cmos_rgb565_packer_if #(
  parameter int PIX_PER_WORD = 8
);
  logic                      vs_i;
  logic                      de_i;
  logic [15:0]               pdata_i;
  logic                      wr_en_o;
  logic [16*PIX_PER_WORD-1:0] wr_data_o;
  logic                      frame_start_o;
  logic                      frame_done_o;
  logic                      line_err_o;
  logic [7:0]                frame_cnt_o;

  modport master (
    output vs_i, de_i, pdata_i,
    input  wr_en_o, wr_data_o, frame_start_o, frame_done_o, line_err_o, frame_cnt_o
  );

  modport slave (
    input  vs_i, de_i, pdata_i,
    output wr_en_o, wr_data_o, frame_start_o, frame_done_o, line_err_o, frame_cnt_o
  );
endinterface

// File: rtl/cmos_rgb565_packer.sv
// rtl/cmos_rgb565_packer.sv - frame-aware RGB565 pixel packer for the frame-buffer write FIFO
//
// Purpose: counts pixels/lines of each frame against H_ACTIVE x V_ACTIVE,
//          packs PIX_PER_WORD consecutive pixels into one word, flags
//          malformed lines and counts frames that completed without error.
// Ports:
//   pclk   pixel clock
//   rst_n  asynchronous active-low reset
//   bus    cmos_rgb565_packer_if.slave (vs_i, de_i, pdata_i in;
//          wr_en_o, wr_data_o, frame_start_o, frame_done_o,
//          line_err_o, frame_cnt_o out)
module cmos_rgb565_packer #(
  parameter int H_ACTIVE     = 1024,
  parameter int V_ACTIVE     = 768,
  parameter int PIX_PER_WORD = 8
) (
  input  logic                 pclk,
  input  logic                 rst_n,
  cmos_rgb565_packer_if.slave  bus
);

  localparam int HW = $clog2(H_ACTIVE + 1);
  localparam int VW = $clog2(V_ACTIVE + 1);
  localparam int PW = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam int DW = 16 * PIX_PER_WORD;

  localparam logic [HW-1:0] H_MAX  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_MAX  = VW'(V_ACTIVE);
  localparam logic [PW-1:0] P_LAST = PW'(PIX_PER_WORD - 1);

  typedef enum logic [1:0] {
    WAIT_VS,
    ACTIVE,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic            vs_q, vs_d;
  logic            de_q, de_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [VW-1:0]   vcnt_q, vcnt_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic [DW-1:0]   word_q, word_d;
  logic            line_bad_q, line_bad_d;
  logic            wr_en_q, wr_en_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic            frame_start_q, frame_start_d;
  logic            frame_done_q, frame_done_d;
  logic            line_err_q, line_err_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;

  logic vs_rise;
  logic de_fall;

  assign vs_rise = bus.vs_i & ~vs_q;
  assign de_fall = ~bus.de_i & de_q;

  always_comb begin
    state_d       = state_q;
    vs_d          = bus.vs_i;
    de_d          = bus.de_i;
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    pcnt_d        = pcnt_q;
    word_d        = word_q;
    line_bad_d    = line_bad_q;
    wr_en_d       = 1'b0;
    wr_data_d     = wr_data_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    line_err_d    = line_err_q;
    frame_cnt_d   = frame_cnt_q;

    if (vs_rise) begin
      // A vsync rise always restarts capture, abandoning any frame in
      // flight together with its partial word; a pixel on this cycle is lost.
      state_d       = ACTIVE;
      hcnt_d        = '0;
      vcnt_d        = '0;
      pcnt_d        = '0;
      line_bad_d    = 1'b0;
      line_err_d    = 1'b0;
      frame_start_d = 1'b1;
    end else if (state_q == ACTIVE) begin
      if (bus.de_i) begin
        if ((hcnt_q < H_MAX) && (vcnt_q < V_MAX)) begin
          word_d[int'(pcnt_q)*16 +: 16] = bus.pdata_i;
          hcnt_d = hcnt_q + 1'b1;
          if (pcnt_q == P_LAST) begin
            // Emit the word including the pixel arriving this cycle.
            pcnt_d    = '0;
            wr_en_d   = 1'b1;
            wr_data_d = word_d;
          end else begin
            pcnt_d = pcnt_q + 1'b1;
          end
        end else begin
          // Overlong line: drop the pixel, hcnt stays saturated at H_ACTIVE.
          line_bad_d = 1'b1;
        end
      end else if (de_fall) begin
        if ((hcnt_q != H_MAX) || line_bad_q) begin
          line_err_d = 1'b1;
        end
        pcnt_d     = '0;
        hcnt_d     = '0;
        line_bad_d = 1'b0;
        if (vcnt_q != V_MAX) begin
          vcnt_d = vcnt_q + 1'b1;
        end
        if (vcnt_d == V_MAX) begin
          state_d      = DONE;
          frame_done_d = 1'b1;
          // The closing line's own error counts against the frame too.
          if (!line_err_d) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT_VS;
      vs_q          <= 1'b0;
      de_q          <= 1'b0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      pcnt_q        <= '0;
      word_q        <= '0;
      line_bad_q    <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_data_q     <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      line_err_q    <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      vs_q          <= vs_d;
      de_q          <= de_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      pcnt_q        <= pcnt_d;
      word_q        <= word_d;
      line_bad_q    <= line_bad_d;
      wr_en_q       <= wr_en_d;
      wr_data_q     <= wr_data_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      line_err_q    <= line_err_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign bus.wr_en_o       = wr_en_q;
  assign bus.wr_data_o     = wr_data_q;
  assign bus.frame_start_o = frame_start_q;
  assign bus.frame_done_o  = frame_done_q;
  assign bus.line_err_o    = line_err_q;
  assign bus.frame_cnt_o   = frame_cnt_q;

endmodule
